// File: rtl/npc_lsu_pkg.sv
// Shared types and constants for the npc load/store unit.
// Encodes RISC-V funct3 sizes, completion error codes and the LSU state set.
package npc_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  // Byte-enable pattern for an access of 1/2/4/8 bytes at offset 0.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/npc_lsu_align.sv
// Combinational access checks, store lane shifting and load extraction.
// Purely a function of funct3, the byte offset and the data words.
module lsu_align import npc_lsu_pkg::*; #(
  parameter  int XLEN  = 32,
  localparam int BE_W  = XLEN / 8,
  localparam int OFF_W = $clog2(BE_W)
) (
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] off,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rdata,
  output logic             illegal,
  output logic             misalign,
  output logic [XLEN-1:0]  wdata_sh,
  output logic [BE_W-1:0]  wmask,
  output logic [XLEN-1:0]  rdata_ext
);

  localparam bit HAS_D = (XLEN == 64);

  logic [OFF_W+2:0] sh;
  logic [XLEN-1:0]  lane;
  logic [XLEN-1:0]  keep;
  logic             sgn;

  assign sh = {off, 3'b000};

  // Doubleword and LWU only exist on RV64; stores have no unsigned forms.
  always_comb begin
    if (is_store)
      illegal = funct3[2] || ((funct3[1:0] == 2'b11) && !HAS_D);
    else
      illegal = (funct3 == 3'b111) || (((funct3 == F3_D) || (funct3 == F3_WU)) && !HAS_D);
  end

  always_comb begin
    case (funct3[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = off[0];
      2'b10:   misalign = |off[1:0];
      default: misalign = |off;
    endcase
  end

  assign wdata_sh = wdata << sh;
  assign wmask    = is_store ? (BE_W'(size_mask(funct3[1:0])) << off) : '0;

  assign lane = rdata >> sh;

  // Mask the lane to the access size, then fill the upper bits for signed loads.
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        keep = XLEN'(8'hFF);
        sgn  = lane[7];
      end
      2'b01: begin
        keep = XLEN'(16'hFFFF);
        sgn  = lane[15];
      end
      2'b10: begin
        keep = XLEN'(32'hFFFF_FFFF);
        sgn  = lane[31];
      end
      default: begin
        keep = '1;
        sgn  = 1'b0;
      end
    endcase
    rdata_ext = (lane & keep) | ((sgn && !funct3[2]) ? ~keep : '0);
  end

endmodule

// File: rtl/npc_lsu.sv
// Multi-cycle load/store unit: accepts one op, issues a valid/ready memory
// request, waits for the response and returns extended load data or an error.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an op; bad ops go straight to DONE
// REQ   | mem_req_valid=1, request fields held until mem_req_ready
// WAIT  | waiting for mem_resp_valid, timeout counter running
// DONE  | out_valid=1 for this single cycle, then back to IDLE
module npc_lsu import npc_lsu_pkg::*; #(
  parameter  int XLEN    = 32,
  parameter  int ADDR_W  = 32,
  parameter  int TIMEOUT = 0,
  parameter  int TO_W    = 16,
  localparam int BE_W    = XLEN / 8,
  localparam int OFF_W   = $clog2(BE_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [4:0]        in_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [BE_W-1:0]   mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_rdata,
  output logic [4:0]        out_rd,
  output logic              out_wen,
  output logic [1:0]        out_err
);

  lsu_state_t        state;
  logic              is_store_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [4:0]        rd_q;
  logic [TO_W-1:0]   to_cnt;

  logic              idle;
  logic              al_store;
  logic [2:0]        al_f3;
  logic [OFF_W-1:0]  al_off;
  logic              illegal;
  logic              misalign;
  logic [XLEN-1:0]   wdata_sh;
  logic [XLEN-1:0]   rdata_ext;
  logic              to_hit;

  assign idle     = (state == IDLE);
  assign in_ready = idle;

  // Checks see the live op in IDLE so errors resolve on the accept edge;
  // afterwards everything comes from the latched copy and stays stable.
  assign al_store = idle ? in_is_store : is_store_q;
  assign al_f3    = idle ? in_funct3 : f3_q;
  assign al_off   = idle ? in_addr[OFF_W-1:0] : addr_q[OFF_W-1:0];

  lsu_align #(.XLEN(XLEN)) u_align (
    .is_store  (al_store),
    .funct3    (al_f3),
    .off       (al_off),
    .wdata     (wdata_q),
    .rdata     (mem_resp_rdata),
    .illegal   (illegal),
    .misalign  (misalign),
    .wdata_sh  (wdata_sh),
    .wmask     (mem_req_wmask),
    .rdata_ext (rdata_ext)
  );

  assign mem_req_wen   = is_store_q;
  assign mem_req_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_req_wdata = is_store_q ? wdata_sh : '0;

  assign to_hit = (TIMEOUT != 0) && (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      is_store_q    <= 1'b0;
      f3_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_q          <= '0;
      to_cnt        <= '0;
      mem_req_valid <= 1'b0;
      out_valid     <= 1'b0;
      out_rdata     <= '0;
      out_rd        <= '0;
      out_wen       <= 1'b0;
      out_err       <= ERR_OK;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            is_store_q <= in_is_store;
            f3_q       <= in_funct3;
            addr_q     <= in_addr;
            wdata_q    <= in_wdata;
            rd_q       <= in_rd;
            if (illegal || misalign) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_err   <= illegal ? ERR_ILLEGAL : ERR_MISALIGN;
              out_rdata <= '0;
              out_rd    <= in_rd;
              out_wen   <= 1'b0;
            end else begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state         <= WAIT;
            mem_req_valid <= 1'b0;
            to_cnt        <= '0;
          end
        end
        WAIT: begin
          to_cnt <= to_cnt + TO_W'(1);
          // A response arriving on the timeout cycle still counts as success.
          if (mem_resp_valid) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_err   <= ERR_OK;
            out_rd    <= rd_q;
            out_wen   <= !is_store_q;
            out_rdata <= is_store_q ? '0 : rdata_ext;
          end else if (to_hit) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_err   <= ERR_TIMEOUT;
            out_rd    <= rd_q;
            out_wen   <= 1'b0;
            out_rdata <= '0;
          end
        end
        DONE: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_wen   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
